// File: rtl/regfile_wb_queue_if.sv
// Bus bundle for the register-file write-back queue: producer handshake,
// register-file write port, decode bypass lookup and occupancy status.
// The slave modport is the queue itself; master is its surroundings.
interface regfile_wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [AW-1:0]            in_addr;
    logic [DW-1:0]            in_data;

    logic                     rf_drain_en;
    logic                     rf_we;
    logic [AW-1:0]            rf_a3;
    logic [DW-1:0]            rf_wd;

    logic [AW-1:0]            rd_a1;
    logic [AW-1:0]            rd_a2;
    logic                     fwd1_hit;
    logic [DW-1:0]            fwd1_data;
    logic                     fwd2_hit;
    logic [DW-1:0]            fwd2_data;

    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    logic                     full;

    modport slave (
        input  in_valid, in_addr, in_data, rf_drain_en, rd_a1, rd_a2,
        output in_ready, rf_we, rf_a3, rf_wd,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
               count, empty, full
    );

    modport master (
        output in_valid, in_addr, in_data, rf_drain_en, rd_a1, rd_a2,
        input  in_ready, rf_we, rf_a3, rf_wd,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
               count, empty, full
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the 32x32 register file write port.
// Producers push (addr, data); the head drains one entry per cycle whenever
// rf_drain_en allows. Writes to r0 complete the handshake but are dropped.
// Build option: define WBQ_BYPASS_EN to build the decode read bypass
// (newest queued value for rd_a1/rd_a2). Without it the fwd outputs are
// tied to zero and decode must stall while the queue is not empty.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    regfile_wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic empty;
    logic full;
    logic push;
    logic store;
    logic pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Full blocks acceptance even when the head pops this cycle.
    assign push  = bus.in_valid && !full;
    assign store = push && (bus.in_addr != '0);
    assign pop   = !empty && bus.rf_drain_en;

    // Entry payload; no reset, validity is carried by count/pointers alone.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_addr[wr_ptr] <= bus.in_addr;
            mem_data[wr_ptr] <= bus.in_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({store, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.rf_we    = pop;
    assign bus.rf_a3    = empty ? '0 : mem_addr[rd_ptr];
    assign bus.rf_wd    = empty ? '0 : mem_data[rd_ptr];
    assign bus.in_ready = !full;
    assign bus.count    = count_q;
    assign bus.empty    = empty;
    assign bus.full     = full;

`ifdef WBQ_BYPASS_EN
    logic          hit1;
    logic          hit2;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;

    // Walk valid entries oldest to newest so the newest match overrides older ones.
    always_comb begin
        hit1  = 1'b0;
        hit2  = 1'b0;
        data1 = '0;
        data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q) begin
                if ((bus.rd_a1 != '0) && (mem_addr[rd_ptr + PW'(k)] == bus.rd_a1)) begin
                    hit1  = 1'b1;
                    data1 = mem_data[rd_ptr + PW'(k)];
                end
                if ((bus.rd_a2 != '0) && (mem_addr[rd_ptr + PW'(k)] == bus.rd_a2)) begin
                    hit2  = 1'b1;
                    data2 = mem_data[rd_ptr + PW'(k)];
                end
            end
        end
    end

    assign bus.fwd1_hit  = hit1;
    assign bus.fwd1_data = data1;
    assign bus.fwd2_hit  = hit2;
    assign bus.fwd2_data = data2;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{bus.rd_a1, bus.rd_a2};

    assign bus.fwd1_hit  = 1'b0;
    assign bus.fwd1_data = '0;
    assign bus.fwd2_hit  = 1'b0;
    assign bus.fwd2_data = '0;
`endif

endmodule
